// File: rtl/dom_sbox_pkg.sv
// dom_sbox_pkg: GF(2^2) normal-basis helpers and share-pair indexing for the DOM-masked Canright S-box.
package dom_sbox_pkg;

    function automatic logic [1:0] gf22_mul(input logic [1:0] a, input logic [1:0] b);
        logic t;
        t = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ t, (a[0] & b[0]) ^ t};
    endfunction

    function automatic logic [1:0] gf22_sq(input logic [1:0] a);
        return {a[0], a[1]};
    endfunction

    function automatic logic [1:0] gf22_scale_n(input logic [1:0] a);
        return {a[0], a[1] ^ a[0]};
    endfunction

    function automatic int num_pairs(input int s);
        return s * (s - 1) / 2;
    endfunction

    // Lexicographic index of the unordered pair {i,j} among s shares; 0 for i==j.
    function automatic int pair_idx(input int s, input int i, input int j);
        int lo, hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return (lo == hi) ? 0 : lo * (2 * s - lo - 1) / 2 + hi - lo - 1;
    endfunction

endpackage

// File: rtl/dom_gf24_inverter_pipe_if.sv
// dom_gf24_inverter_pipe_if: operand/result bundle of the masked GF(2^4) inverter.
// RxDI exists only when DOM_INV_OUT_REFRESH_EN is defined.
interface dom_gf24_inverter_pipe_if import dom_sbox_pkg::*; #(
    parameter int SHARES = 2
);
    localparam int NP = num_pairs(SHARES);
    logic                  EnxSI;
    logic                  InValidxSI;
    logic [4*SHARES-1:0]   XxDI;
    logic [6*NP-1:0]       ZxDI;
    logic [4*SHARES-1:0]   QxDO;
    logic                  OutValidxSO;
`ifdef DOM_INV_OUT_REFRESH_EN
    logic [4*(SHARES-1)-1:0] RxDI;
    modport master (output EnxSI, InValidxSI, XxDI, ZxDI, RxDI, input QxDO, OutValidxSO);
    modport slave  (input EnxSI, InValidxSI, XxDI, ZxDI, RxDI, output QxDO, OutValidxSO);
`else
    modport master (output EnxSI, InValidxSI, XxDI, ZxDI, input QxDO, OutValidxSO);
    modport slave  (input EnxSI, InValidxSI, XxDI, ZxDI, output QxDO, OutValidxSO);
`endif
endinterface

// File: rtl/dom_gf22_mul_pipe.sv
// dom_gf22_mul_pipe: DOM-indep GF(2^2) multiplier, one enabled register stage, any share count.
module dom_gf22_mul_pipe import dom_sbox_pkg::*; #(
    parameter int SHARES = 2
) (
    input  logic                              ClkxCI,
    input  logic                              RstxBI,
    input  logic                              EnxSI,
    input  logic [2*SHARES-1:0]               XxDI,
    input  logic [2*SHARES-1:0]               YxDI,
    input  logic [2*num_pairs(SHARES)-1:0]    ZxDI,
    output logic [2*SHARES-1:0]               QxDO
);
    localparam int NT = SHARES * SHARES;

    logic [2*NT-1:0] w_t, r_t;

    // Term (i,j) lives at slot i*SHARES+j; cross terms are blinded before the register.
    always_comb begin
        w_t = '0;
        for (int i = 0; i < SHARES; i++)
            for (int j = 0; j < SHARES; j++)
                w_t[2*(i*SHARES+j) +: 2] = gf22_mul(XxDI[2*i +: 2], YxDI[2*j +: 2])
                    ^ ((i == j) ? 2'b00 : ZxDI[2*pair_idx(SHARES, i, j) +: 2]);
    end

    always_ff @(posedge ClkxCI or negedge RstxBI)
        if (!RstxBI) r_t <= '0;
        else if (EnxSI) r_t <= w_t;

    always_comb begin
        QxDO = '0;
        for (int i = 0; i < SHARES; i++)
            for (int j = 0; j < SHARES; j++)
                QxDO[2*i +: 2] = QxDO[2*i +: 2] ^ r_t[2*(i*SHARES+j) +: 2];
    end
endmodule

// File: rtl/dom_gf24_inverter_pipe.sv
// dom_gf24_inverter_pipe: DOM-masked Canright GF(2^4) inverter, two enabled stages plus optional output register.
// DOM_INV_OUT_REFRESH_EN adds output-share refresh through RxDI and requires OUT_REG=1.
module dom_gf24_inverter_pipe import dom_sbox_pkg::*; #(
    parameter int SHARES  = 2,
    parameter int OUT_REG = 0
) (
    input logic                     ClkxCI,
    input logic                     RstxBI,
    dom_gf24_inverter_pipe_if.slave io
);
    localparam int NP = num_pairs(SHARES);
    localparam int L  = 2 + OUT_REG;
    localparam int W  = 4 * SHARES;

    logic [2*SHARES-1:0] w_a, w_b, w_c, w_e, w_ab, w_ae, w_be;
    logic [2*SHARES-1:0] r_a, r_b, r_c;
    logic [W-1:0]        w_q;
    logic [L-1:0]        r_v;

    for (genvar i = 0; i < SHARES; i++) begin : g_sh
        assign w_a[2*i +: 2] = io.XxDI[4*i+2 +: 2];
        assign w_b[2*i +: 2] = io.XxDI[4*i +: 2];
        assign w_c[2*i +: 2] = gf22_scale_n(gf22_sq(w_a[2*i +: 2] ^ w_b[2*i +: 2]));
        // Squaring in GF(2^2) is inversion, so E is the share of the inverted norm.
        assign w_e[2*i +: 2] = gf22_sq(r_c[2*i +: 2] ^ w_ab[2*i +: 2]);
        assign w_q[4*i +: 4] = {w_be[2*i +: 2], w_ae[2*i +: 2]};
    end

    always_ff @(posedge ClkxCI or negedge RstxBI)
        if (!RstxBI) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
            r_v <= '0;
        end else if (io.EnxSI) begin
            r_a <= w_a;
            r_b <= w_b;
            r_c <= w_c;
            r_v <= {r_v[L-2:0], io.InValidxSI};
        end

    assign io.OutValidxSO = r_v[L-1];

    dom_gf22_mul_pipe #(.SHARES(SHARES)) u_ab (
        .ClkxCI, .RstxBI, .EnxSI(io.EnxSI),
        .XxDI(w_a), .YxDI(w_b), .ZxDI(io.ZxDI[0 +: 2*NP]), .QxDO(w_ab)
    );

    dom_gf22_mul_pipe #(.SHARES(SHARES)) u_ae (
        .ClkxCI, .RstxBI, .EnxSI(io.EnxSI),
        .XxDI(r_a), .YxDI(w_e), .ZxDI(io.ZxDI[2*NP +: 2*NP]), .QxDO(w_ae)
    );

    dom_gf22_mul_pipe #(.SHARES(SHARES)) u_be (
        .ClkxCI, .RstxBI, .EnxSI(io.EnxSI),
        .XxDI(r_b), .YxDI(w_e), .ZxDI(io.ZxDI[4*NP +: 2*NP]), .QxDO(w_be)
    );

`ifdef DOM_INV_OUT_REFRESH_EN
    logic [W-1:0] w_r;

    // Last share absorbs every R_i so the recombined value is untouched.
    always_comb begin
        w_r = '0;
        for (int i = 0; i < SHARES - 1; i++) begin
            w_r[4*i +: 4] = io.RxDI[4*i +: 4];
            w_r[W-1 -: 4] = w_r[W-1 -: 4] ^ io.RxDI[4*i +: 4];
        end
    end
`endif

    if (OUT_REG != 0) begin : g_oreg
        logic [W-1:0] r_q;
        always_ff @(posedge ClkxCI or negedge RstxBI)
            if (!RstxBI) r_q <= '0;
            else if (io.EnxSI) r_q <= w_q
`ifdef DOM_INV_OUT_REFRESH_EN
                ^ w_r
`endif
                ;
        assign io.QxDO = r_q;
    end else begin : g_comb
`ifdef DOM_INV_OUT_REFRESH_EN
        $error("DOM_INV_OUT_REFRESH_EN requires OUT_REG=1");
`endif
        assign io.QxDO = w_q;
    end
endmodule

// File: tb/tb_dom_gf24_inverter_pipe.sv
// tb_dom_gf24_inverter_pipe: directed checks of the masked GF(2^4) inverter at 2, 3 and 4 shares.
// Expected inverses come from a hand-computed normal-basis table.
module tb_dom_gf24_inverter_pipe;
`ifdef DOM_INV_OUT_REFRESH_EN
    localparam int OR0 = 1;
`else
    localparam int OR0 = 0;
`endif
    localparam int L2 = 2 + OR0;
    localparam int L3 = 3;
    localparam int L4 = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dom_gf24_inverter_pipe_if #(.SHARES(2)) i2 ();
    dom_gf24_inverter_pipe_if #(.SHARES(3)) i3 ();
    dom_gf24_inverter_pipe_if #(.SHARES(4)) i4 ();

    dom_gf24_inverter_pipe #(.SHARES(2), .OUT_REG(OR0)) d2 (.ClkxCI(clk), .RstxBI(rst_n), .io(i2));
    dom_gf24_inverter_pipe #(.SHARES(3), .OUT_REG(1))   d3 (.ClkxCI(clk), .RstxBI(rst_n), .io(i3));
    dom_gf24_inverter_pipe #(.SHARES(4), .OUT_REG(1))   d4 (.ClkxCI(clk), .RstxBI(rst_n), .io(i4));

    logic [3:0] inv_t [16] = '{4'h0, 4'hC, 4'h8, 4'h4, 4'h3, 4'hA, 4'h7, 4'h6,
                               4'h2, 4'hD, 4'h5, 4'hE, 4'h1, 4'h9, 4'hB, 4'hF};
    logic [1:0] mt [16] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd3, 2'd1,
                            2'd0, 2'd3, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};

    int n_cmp = 0;
    int n_bad = 0;
    int n_in, n_out;
    bit zz, en_r;
    logic [3:0] hx [$];
    logic       hv [$];

    function automatic logic [1:0] m4(input logic [1:0] a, input logic [1:0] b);
        return mt[{a, b}];
    endfunction

    function automatic logic [3:0] gmul(input logic [3:0] x, input logic [3:0] y);
        logic [1:0] s;
        s = m4(m4(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]), 2'b10);
        return {m4(x[3:2], y[3:2]) ^ s, m4(x[1:0], y[1:0]) ^ s};
    endfunction

    function automatic logic [15:0] mask(input logic [3:0] v, input int s);
        logic [15:0] m;
        logic [3:0]  acc;
        m = 16'($urandom());
        acc = v;
        for (int i = 0; i < s - 1; i++) acc ^= m[4*i +: 4];
        m[4*(s-1) +: 4] = acc;
        return m;
    endfunction

    function automatic logic [3:0] rec(input logic [15:0] q, input int s);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < s; i++) r ^= q[4*i +: 4];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_one(input string t, input logic [15:0] q, input logic v, input int s, input int l);
        chk({t, "_vld"}, 16'(v), 16'(hv[l-1]));
        if (hv[l-1]) begin
            chk({t, "_inv"}, 16'(rec(q, s)), 16'(inv_t[hx[l-1]]));
            if (hx[l-1] != 4'h0) chk({t, "_unit"}, 16'(gmul(hx[l-1], rec(q, s))), 16'hF);
        end
    endtask

    task automatic chk_rst(input string t);
        chk({t, "_q2"}, 16'(i2.QxDO), 16'h0);
        chk({t, "_q3"}, 16'(i3.QxDO), 16'h0);
        chk({t, "_q4"}, i4.QxDO, 16'h0);
        chk({t, "_v"}, 16'({i2.OutValidxSO, i3.OutValidxSO, i4.OutValidxSO}), 16'h0);
    endtask

    task automatic clear_hist();
        hx.delete();
        hv.delete();
        repeat (3) begin
            hx.push_front(4'h0);
            hv.push_front(1'b0);
        end
    endtask

    task automatic step(input logic [3:0] v, input logic vld, input logic en);
        logic [15:0] m;
        logic [63:0] z;
        z = zz ? 64'd0 : {$urandom(), $urandom()};
        m = mask(v, 2); i2.XxDI = m[7:0];
        m = mask(v, 3); i3.XxDI = m[11:0];
        m = mask(v, 4); i4.XxDI = m;
        i2.ZxDI = z[5:0];
        i3.ZxDI = z[17:0];
        i4.ZxDI = z[35:0];
        {i2.EnxSI, i3.EnxSI, i4.EnxSI} = {3{en}};
        {i2.InValidxSI, i3.InValidxSI, i4.InValidxSI} = {3{vld}};
`ifdef DOM_INV_OUT_REFRESH_EN
        z = {$urandom(), $urandom()};
        i2.RxDI = z[3:0];
        i3.RxDI = z[7:0];
        i4.RxDI = z[11:0];
`endif
        @(posedge clk);
        #1;
        if (en) begin
            hx.push_front(v);
            hv.push_front(vld);
            n_in += int'(vld);
            if (i2.OutValidxSO) n_out++;
        end
        check_one("s2", 16'(i2.QxDO), i2.OutValidxSO, 2, L2);
        check_one("s3", 16'(i3.QxDO), i3.OutValidxSO, 3, L3);
        check_one("s4", i4.QxDO, i4.OutValidxSO, 4, L4);
    endtask

    initial begin
        rst_n = 1'b1;
        zz = 1'b0;
        n_in = 0;
        n_out = 0;
        step(4'h0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1 chk_rst("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_hist();
        // full sweep, back-to-back
        for (int v = 0; v < 16; v++) step(4'(v), 1'b1, 1'b1);
        repeat (3) step(4'($urandom()), 1'b0, 1'b1);
        // 20-operand stream under a pseudo-random enable
        n_in = 0;
        n_out = 0;
        for (int k = 0; k < 400 && n_in < 20; k++) begin
            en_r = 1'($urandom());
            step(4'($urandom()), 1'b1, en_r);
        end
        repeat (3) step(4'($urandom()), 1'b0, 1'b1);
        chk("stream_cnt", 16'(n_out), 16'(n_in));
        // zero randomness must not change recombined results
        zz = 1'b1;
        for (int v = 0; v < 16; v++) step(4'(15 - v), 1'b1, 1'b1);
        repeat (3) step(4'h0, 1'b0, 1'b1);
        zz = 1'b0;
        // reset with two operands in flight
        step(4'h5, 1'b1, 1'b1);
        step(4'h9, 1'b1, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk_rst("mid");
        @(posedge clk);
        #1 chk_rst("mid_hold");
        rst_n = 1'b1;
        clear_hist();
        step(4'h6, 1'b1, 1'b1);
        step(4'h2, 1'b0, 1'b0);
        step(4'h3, 1'b0, 1'b1);
        step(4'h1, 1'b0, 1'b0);
        step(4'h4, 1'b0, 1'b1);
        step(4'h7, 1'b0, 1'b1);
        step(4'h8, 1'b0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
